sync_fifo_flags: RTL
====================

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of storage entries; must equal 2**ADDR_WIDTH.
- ADDR_WIDTH, 4, storage address width.
- AF_LEVEL, 14, almost_full threshold (1..DEPTH-1).
- AE_LEVEL, 2, almost_empty threshold (1..DEPTH-1).
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

REQ-002 Ports SHALL be, one per line:
- clk, in, 1, sole clock; all state changes on its rising edge.
- rst, in, 1, synchronous active-high reset.
- wr_en, in, 1, write request.
- data_in, in, WIDTH, write data.
- rd_en, in, 1, read request (FWFT=1: pop/acknowledge of head word).
- data_out, out, WIDTH, read data.
- rd_valid, out, 1, data_out holds a valid word.
- full, out, 1, count == DEPTH.
- empty, out, 1, count == 0.
- almost_full, out, 1, count >= AF_LEVEL.
- almost_empty, out, 1, count <= AE_LEVEL.
- count, out, ADDR_WIDTH+1, number of stored words, 0..DEPTH.
- overflow, out, 1, sticky: write attempted while full.
- underflow, out, 1, sticky: read attempted while empty.
- clr_err, in, 1, clears overflow and underflow.

Function
REQ-003 A write SHALL be accepted iff wr_en && !full; data_in is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-004 A read SHALL be accepted iff rd_en && !empty; rd_ptr increments modulo DEPTH.
REQ-005 Flags SHALL be evaluated against the count before the edge, so on a full FIFO a simultaneous write is rejected even if a read is accepted.
REQ-006 On an empty FIFO with simultaneous requests, the read SHALL be rejected and the write accepted.
REQ-007 count SHALL update on each edge:
- +1 for write only.
- -1 for read only.
- unchanged when both or neither request is accepted.
REQ-008 full, empty, almost_full and almost_empty SHALL be registered outputs consistent with count in the same cycle.
REQ-009 When FWFT=0, an accepted read SHALL load data_out with mem[rd_ptr] on that edge (1-cycle latency) and pulse rd_valid high for exactly the next cycle; otherwise data_out holds its value.
REQ-010 When FWFT=1, data_out SHALL present mem[rd_ptr] continuously and rd_valid SHALL equal !empty; an accepted read exposes the next word in the following cycle.
REQ-011 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated words.
REQ-012 A word written into an empty FIFO SHALL be readable no earlier than the cycle after its write.
REQ-013 overflow SHALL set on wr_en && full, and underflow SHALL set on rd_en && empty; both hold until clr_err or rst.
REQ-014 When clr_err coincides with a new error event, the flag SHALL be set, not cleared.
REQ-015 Rejected requests SHALL not alter pointers, count, storage or data_out.

Reset
REQ-016 With rst high at an edge, the block SHALL set:
- wr_ptr, rd_ptr and count to 0.
- empty=1, almost_empty=1, full=0, almost_full=0.
- rd_valid=0, data_out=0, overflow=0, underflow=0.
REQ-017 rst SHALL take priority over all requests; reset mid-operation discards contents, and wr_en/rd_en in the reset cycle are ignored.
REQ-018 Storage array contents SHALL not be reset; no output may depend on them until they are written.

Verification
REQ-019 Reset, then write 0x11,0x22,0x33 and read 3 with FWFT=0 -> data_out 0x11,0x22,0x33 each one cycle after its read, rd_valid pulses 3 times, and count 3->0 with empty=1 at the end.
REQ-020 Write 16 words with defaults -> almost_full rises when count=14 and full at 16; a 17th write sets overflow while count stays 16 and data is unchanged.
REQ-021 With full=1 assert wr_en and rd_en together -> read accepted, write rejected, count=15, overflow=1; then with count=8 assert both -> count stays 8 and the order is preserved.
REQ-022 Read on empty -> underflow=1, count=0, data_out unchanged; clr_err pulse -> underflow=0; clr_err together with a read on empty -> underflow stays 1.
REQ-023 Write 40 words and read continuously, keeping count between 1 and 15 -> read data matches write order across pointer wraps, with no spurious flags.
REQ-024 With FWFT=1, write 0xA5 -> next cycle data_out=0xA5 and rd_valid=1; one read -> empty=1, rd_valid=0; reset asserted at count=9 -> all outputs at REQ-016 values the next cycle.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with registered status flags, sticky error flags
// and a selectable registered or first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [ADDR_WIDTH:0] FULL_N = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_N   = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_N   = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  // Acceptance uses the registered flags, i.e. the pre-edge count.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    count_nxt = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count        <= count_nxt;
      full         <= (count_nxt == FULL_N);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_N);
      almost_empty <= (count_nxt <= AE_N);
      // A new error event wins over a coincident clear.
      overflow  <= (wr_en && full) || (overflow && !clr_err);
      underflow <= (rd_en && empty) || (underflow && !clr_err);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Masked while empty so unwritten storage never reaches the port.
      assign data_out = empty ? '0 : mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      logic             valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_ok;
          if (rd_ok) begin
            dout_q <= mem[rd_ptr];
          end
        end
      end

      assign data_out = dout_q;
      assign rd_valid = valid_q;
    end
  endgenerate

endmodule
